// File: rtl/gcd_operand_loader.sv
// Operand loader in front of the GCD core. It synchronises and debounces the
// enter key, then assembles operands A and B from four nibble entries. The
// finished pair is offered to the core over a valid/ready handshake.
//
// state | meaning
// A_HI  | waiting for the high nibble of operand A
// A_LO  | waiting for the low nibble of operand A
// B_HI  | waiting for the high nibble of operand B
// B_LO  | waiting for the low nibble of operand B
// HOLD  | operand pair offered to the core; presses are discarded
module gcd_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       enter_key,
    input  logic       ops_ready,
    output logic       ops_valid,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [7:0] mag_a,
    output logic [7:0] mag_b,
    output logic [1:0] phase,
    output logic [7:0] preview
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A_HI = 3'd0,
        S_A_LO = 3'd1,
        S_B_HI = 3'd2,
        S_B_LO = 3'd3,
        S_HOLD = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_q, press_d;
    logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [7:0]      mag_a_q, mag_b_q;
    logic [7:0]      preview_q, preview_d;

    function automatic logic [7:0] abs8(input logic [7:0] v);
        return v[7] ? (~v + 8'd1) : v;
    endfunction

    // Debounce: level flips only after CNT_TC+1 consecutive disagreeing samples;
    // a press is the registered 0->1 flip of the debounced level.
    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_TC) begin
                db_d    = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Two-flop synchroniser and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= enter_key;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_A_HI;
        else        state_q <= state_d;
    end

    // FSM next state: nibble entries advance on press, HOLD leaves on transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A_HI:  if (press_q)   state_d = S_A_LO;
            S_A_LO:  if (press_q)   state_d = S_B_HI;
            S_B_HI:  if (press_q)   state_d = S_B_LO;
            S_B_LO:  if (press_q)   state_d = S_HOLD;
            S_HOLD:  if (ops_ready) state_d = S_A_HI;
            default:                state_d = S_A_HI;
        endcase
    end

    // FSM outputs: phase/valid from state, next operand and preview values on press.
    always_comb begin
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        preview_d = preview_q;
        phase     = 2'd0;
        ops_valid = 1'b0;
        case (state_q)
            S_A_HI: begin
                phase = 2'd0;
                if (press_q) begin
                    op_a_d[7:4] = sw;
                    preview_d   = {sw, 4'h0};
                end
            end
            S_A_LO: begin
                phase = 2'd1;
                if (press_q) begin
                    op_a_d[3:0] = sw;
                    preview_d   = {op_a_q[7:4], sw};
                end
            end
            S_B_HI: begin
                phase = 2'd2;
                if (press_q) begin
                    op_b_d[7:4] = sw;
                    preview_d   = {sw, 4'h0};
                end
            end
            S_B_LO: begin
                phase = 2'd3;
                if (press_q) begin
                    op_b_d[3:0] = sw;
                    preview_d   = {op_b_q[7:4], sw};
                end
            end
            S_HOLD: begin
                phase     = 2'd0;
                ops_valid = 1'b1;
            end
            default: begin
                phase = 2'd0;
            end
        endcase
    end

    // Operand, magnitude and preview registers; magnitudes track operands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= 8'h00;
            op_b_q    <= 8'h00;
            mag_a_q   <= 8'h00;
            mag_b_q   <= 8'h00;
            preview_q <= 8'h00;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            mag_a_q   <= abs8(op_a_d);
            mag_b_q   <= abs8(op_b_d);
            preview_q <= preview_d;
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign mag_a   = mag_a_q;
    assign mag_b   = mag_b_q;
    assign preview = preview_q;

endmodule
